// File: rtl/wt_cache_pkg.sv
// wt_cache_pkg: cache geometry, the read-miss in-flight entry type and small helpers
// shared by the dcache read-miss arbiter and its round-robin sub-block.
package wt_cache_pkg;

   localparam int unsigned PLEN                = 56;
   localparam int unsigned DCACHE_SET_ASSOC    = 4;
   localparam int unsigned DCACHE_OFFSET_WIDTH = 5;
   localparam int unsigned CACHE_ID_WIDTH      = 3;
   localparam int unsigned MaxRdPorts          = 8;

   typedef struct packed {
      logic                                vld;
      logic [PLEN-DCACHE_OFFSET_WIDTH-1:0] cl_addr;
   } rd_miss_entry_t;

   function automatic logic [DCACHE_SET_ASSOC-1:0] lowest_zero(input logic [DCACHE_SET_ASSOC-1:0] v);
      return ~v & (v + DCACHE_SET_ASSOC'(1));
   endfunction

   function automatic logic [7:0] lfsr8_next(input logic [7:0] l);
      return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
   endfunction

endpackage

// File: rtl/wt_rr_arb_lock.sv
// wt_rr_arb_lock: round-robin pick that holds its choice until granted or killed;
// the pointer moves past the winner only on a grant.
module wt_rr_arb_lock
   import wt_cache_pkg::*;
#(
   parameter int unsigned N = 3
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [N-1:0]              req_i,
   input  logic                      gnt_i,
   input  logic                      kill_i,
   output logic                      lock_o,
   output logic [CACHE_ID_WIDTH-1:0] sel_o
);

   logic [CACHE_ID_WIDTH-1:0] rr_q;
   logic [CACHE_ID_WIDTH-1:0] off;
   logic [CACHE_ID_WIDTH:0]   sum;
   logic [N-1:0]              rot;
   logic                      found;

   assign rot = N'({req_i, req_i} >> rr_q);

   always_comb begin
      found = 1'b0;
      off   = '0;
      for (int i = 0; i < N; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            off   = CACHE_ID_WIDTH'(i);
         end
      end
   end

   assign sum = {1'b0, rr_q} + {1'b0, off};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         rr_q   <= '0;
         lock_o <= 1'b0;
         sel_o  <= '0;
      end else if (lock_o) begin
         if (gnt_i) rr_q <= (sel_o == CACHE_ID_WIDTH'(N-1)) ? '0 : sel_o + CACHE_ID_WIDTH'(1);
         if (gnt_i || kill_i) lock_o <= 1'b0;
      end else if (found) begin
         lock_o <= 1'b1;
         sel_o  <= (sum >= (CACHE_ID_WIDTH+1)'(N)) ? CACHE_ID_WIDTH'(sum - (CACHE_ID_WIDTH+1)'(N))
                                                   : CACHE_ID_WIDTH'(sum);
      end
   end

endmodule

// File: rtl/wt_dcache_rd_miss_arb.sv
// wt_dcache_rd_miss_arb: arbitrates dcache read-controller misses onto the miss unit,
// tracks one in-flight line per port, replays line collisions and picks the refill way.
module wt_dcache_rd_miss_arb
   import wt_cache_pkg::*;
#(
   parameter int unsigned NumPorts = 3,
   parameter logic [7:0]  LfsrSeed = 8'h01
) (
   input  logic                                      clk_i,
   input  logic                                      rst_ni,
   input  logic [NumPorts-1:0]                       miss_req_i,
   input  logic [NumPorts-1:0][PLEN-1:0]             miss_paddr_i,
   input  logic [NumPorts-1:0]                       miss_nc_i,
   input  logic [NumPorts-1:0][2:0]                  miss_size_i,
   input  logic [NumPorts-1:0][DCACHE_SET_ASSOC-1:0] miss_vld_bits_i,
   output logic [NumPorts-1:0]                       miss_ack_o,
   output logic [NumPorts-1:0]                       miss_replay_o,
   output logic [NumPorts-1:0]                       miss_rtrn_vld_o,
   output logic                                      mem_req_o,
   input  logic                                      mem_gnt_i,
   output logic [PLEN-1:0]                           mem_paddr_o,
   output logic                                      mem_nc_o,
   output logic [2:0]                                mem_size_o,
   output logic [CACHE_ID_WIDTH-1:0]                 mem_id_o,
   output logic [DCACHE_SET_ASSOC-1:0]               mem_way_o,
   input  logic                                      mem_rtrn_vld_i,
   input  logic [CACHE_ID_WIDTH-1:0]                 mem_rtrn_id_i
);

   localparam int unsigned WayW = $clog2(DCACHE_SET_ASSOC);

   rd_miss_entry_t [NumPorts-1:0]  tbl_q;
   logic [7:0]                     lfsr_q;
   logic [NumPorts-1:0]            collide;
   logic [NumPorts-1:0]            cand;
   logic                           lock;
   logic                           grant;
   logic                           kill;
   logic [CACHE_ID_WIDTH-1:0]      sel;
   logic [PLEN-1:0]                s_paddr;
   logic                           s_nc;
   logic [2:0]                     s_size;
   logic [DCACHE_SET_ASSOC-1:0]    s_vld;
   logic                           s_coll;

   always_comb begin
      collide         = '0;
      cand            = '0;
      miss_ack_o      = '0;
      miss_rtrn_vld_o = '0;
      for (int p = 0; p < NumPorts; p++) begin
         for (int q = 0; q < NumPorts; q++)
            if (q != p && tbl_q[q].vld && tbl_q[q].cl_addr == miss_paddr_i[p][PLEN-1:DCACHE_OFFSET_WIDTH])
               collide[p] = 1'b1;
         cand[p]            = miss_req_i[p] && !tbl_q[p].vld;
         miss_ack_o[p]      = grant && sel == CACHE_ID_WIDTH'(p);
         miss_rtrn_vld_o[p] = mem_rtrn_vld_i && mem_rtrn_id_i == CACHE_ID_WIDTH'(p) && tbl_q[p].vld;
      end
   end

   always_comb begin
      s_paddr = '0;
      s_nc    = 1'b0;
      s_size  = '0;
      s_vld   = '0;
      s_coll  = 1'b0;
      for (int p = 0; p < NumPorts; p++) begin
         if (sel == CACHE_ID_WIDTH'(p)) begin
            s_paddr = miss_paddr_i[p];
            s_nc    = miss_nc_i[p];
            s_size  = miss_size_i[p];
            s_vld   = miss_vld_bits_i[p];
            s_coll  = collide[p];
         end
      end
   end

   assign miss_replay_o = cand & collide;
   // a locked port whose line became in flight elsewhere is dropped and replayed
   assign grant         = lock && mem_gnt_i && !s_coll;
   assign kill          = lock && s_coll;

   wt_rr_arb_lock #(.N(NumPorts)) i_rr (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .req_i  (cand & ~collide),
      .gnt_i  (grant),
      .kill_i (kill),
      .lock_o (lock),
      .sel_o  (sel)
   );

   assign mem_req_o   = lock && !s_coll;
   assign mem_paddr_o = lock ? s_paddr : '0;
   assign mem_nc_o    = lock && s_nc;
   assign mem_size_o  = lock ? s_size : '0;
   assign mem_id_o    = lock ? sel : '0;
   assign mem_way_o   = (lock && !s_nc) ? (&s_vld ? DCACHE_SET_ASSOC'(1) << lfsr_q[WayW-1:0]
                                                  : lowest_zero(s_vld)) : '0;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tbl_q  <= '0;
         lfsr_q <= LfsrSeed;
      end else begin
         for (int p = 0; p < NumPorts; p++) begin
            if (grant && sel == CACHE_ID_WIDTH'(p)) begin
               tbl_q[p].vld     <= 1'b1;
               tbl_q[p].cl_addr <= miss_paddr_i[p][PLEN-1:DCACHE_OFFSET_WIDTH];
            end
            if (miss_rtrn_vld_o[p]) tbl_q[p].vld <= 1'b0;
         end
         if (grant && &s_vld) lfsr_q <= lfsr8_next(lfsr_q);
      end
   end

   assert property (@(posedge clk_i) disable iff (!rst_ni) mem_rtrn_vld_i |-> |miss_rtrn_vld_o);

endmodule

// File: tb/tb_wt_dcache_rd_miss_arb.sv
// tb_wt_dcache_rd_miss_arb: directed steps with a grant scoreboard for the read-miss arbiter.
module tb_wt_dcache_rd_miss_arb;
   import wt_cache_pkg::*;

   localparam int NP = 3;

   logic                                clk_i = 1'b0;
   logic                                rst_ni = 1'b0;
   logic [NP-1:0]                       miss_req_i;
   logic [NP-1:0][PLEN-1:0]             miss_paddr_i;
   logic [NP-1:0]                       miss_nc_i;
   logic [NP-1:0][2:0]                  miss_size_i;
   logic [NP-1:0][DCACHE_SET_ASSOC-1:0] miss_vld_bits_i;
   logic [NP-1:0]                       miss_ack_o, miss_replay_o, miss_rtrn_vld_o;
   logic                                mem_req_o, mem_gnt_i, mem_nc_o, mem_rtrn_vld_i;
   logic [PLEN-1:0]                     mem_paddr_o;
   logic [2:0]                          mem_size_o;
   logic [CACHE_ID_WIDTH-1:0]           mem_id_o, mem_rtrn_id_i;
   logic [DCACHE_SET_ASSOC-1:0]         mem_way_o;

   typedef struct {
      int                          id;
      logic [PLEN-1:0]             paddr;
      logic [DCACHE_SET_ASSOC-1:0] way;
      logic                        nc;
      logic [2:0]                  size;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_err = 0;

   always #5 clk_i = ~clk_i;

   wt_dcache_rd_miss_arb #(.NumPorts(NP), .LfsrSeed(8'h01)) dut (
      .clk_i           (clk_i),
      .rst_ni          (rst_ni),
      .miss_req_i      (miss_req_i),
      .miss_paddr_i    (miss_paddr_i),
      .miss_nc_i       (miss_nc_i),
      .miss_size_i     (miss_size_i),
      .miss_vld_bits_i (miss_vld_bits_i),
      .miss_ack_o      (miss_ack_o),
      .miss_replay_o   (miss_replay_o),
      .miss_rtrn_vld_o (miss_rtrn_vld_o),
      .mem_req_o       (mem_req_o),
      .mem_gnt_i       (mem_gnt_i),
      .mem_paddr_o     (mem_paddr_o),
      .mem_nc_o        (mem_nc_o),
      .mem_size_o      (mem_size_o),
      .mem_id_o        (mem_id_o),
      .mem_way_o       (mem_way_o),
      .mem_rtrn_vld_i  (mem_rtrn_vld_i),
      .mem_rtrn_id_i   (mem_rtrn_id_i)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic look();
      #3;
   endtask

   task automatic req(input int p, input logic [PLEN-1:0] a, input logic [3:0] vb, input logic nc,
                      input logic [2:0] sz, input logic [3:0] way, input bit push);
      miss_req_i[p]      = 1'b1;
      miss_paddr_i[p]    = a;
      miss_vld_bits_i[p] = vb;
      miss_nc_i[p]       = nc;
      miss_size_i[p]     = sz;
      if (push) exp_q.push_back('{id: p, paddr: a, way: way, nc: nc, size: sz});
   endtask

   task automatic wait_ack(input int p);
      int n = 0;
      while (miss_ack_o[p] !== 1'b1 && n < 20) begin
         step();
         look();
         n++;
      end
      chk($sformatf("ack_wait_p%0d", p), 64'(miss_ack_o[p]), 1);
   endtask

   task automatic rtrn(input int id, input logic [NP-1:0] exp);
      step();
      mem_rtrn_vld_i = 1'b1;
      mem_rtrn_id_i  = CACHE_ID_WIDTH'(id);
      look();
      chk($sformatf("rtrn_id%0d", id), 64'(miss_rtrn_vld_o), 64'(exp));
      step();
      mem_rtrn_vld_i = 1'b0;
   endtask

   always @(negedge clk_i) begin
      if (rst_ni && mem_req_o && mem_gnt_i) begin
         chk("sb_pending", 64'(exp_q.size() != 0), 1);
         if (exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            chk("sb_id", 64'(mem_id_o), 64'(mon_e.id));
            chk("sb_paddr", 64'(mem_paddr_o), 64'(mon_e.paddr));
            chk("sb_ack", 64'(miss_ack_o), 64'(1) << mon_e.id);
            chk("sb_way", 64'(mem_way_o), 64'(mon_e.way));
            chk("sb_nc", 64'(mem_nc_o), 64'(mon_e.nc));
            chk("sb_size", 64'(mem_size_o), 64'(mon_e.size));
         end
      end
   end

   initial begin
      miss_req_i      = '0;
      miss_paddr_i    = '0;
      miss_nc_i       = '0;
      miss_size_i     = '0;
      miss_vld_bits_i = '0;
      mem_gnt_i       = 1'b0;
      mem_rtrn_vld_i  = 1'b0;
      mem_rtrn_id_i   = '0;
      repeat (2) step();
      look();
      chk("rst_mem_req", 64'(mem_req_o), 0);
      chk("rst_pulses", 64'({miss_ack_o, miss_replay_o, miss_rtrn_vld_o}), 0);
      chk("rst_fields", 64'({mem_paddr_o, mem_id_o, mem_way_o}), 0);
      step();
      rst_ni    = 1'b1;
      mem_gnt_i = 1'b1;

      // single request on port 1, partial valid bits
      step();
      req(1, 56'h8000_1000, 4'b1011, 1'b0, 3'b111, 4'b0100, 1'b1);
      look();
      chk("t1_no_req_same_cycle", 64'(mem_req_o), 0);
      wait_ack(1);
      chk("t1_mem_id", 64'(mem_id_o), 1);
      step();
      miss_req_i[1] = 1'b0;
      mem_rtrn_vld_i = 1'b1;
      mem_rtrn_id_i  = 3'd1;
      look();
      chk("t1_rtrn", 64'(miss_rtrn_vld_o), 64'(3'b010));
      step();
      mem_rtrn_vld_i = 1'b0;

      // ports 0 and 2 together from rr_ptr=0
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      step();
      req(0, 56'h8000_2000, 4'b0000, 1'b0, 3'b111, 4'b0001, 1'b1);
      req(2, 56'h8000_3000, 4'b0000, 1'b0, 3'b111, 4'b0001, 1'b1);
      look();
      wait_ack(0);
      step();
      miss_req_i[0] = 1'b0;
      look();
      chk("t2_no_rearb_same_cycle", 64'(mem_req_o), 0);
      wait_ack(2);
      step();
      miss_req_i[2] = 1'b0;
      rtrn(0, 3'b001);
      rtrn(2, 3'b100);
      req(0, 56'h8000_4000, 4'b0000, 1'b0, 3'b111, 4'b0001, 1'b1);
      req(1, 56'h8000_5000, 4'b0000, 1'b0, 3'b111, 4'b0001, 1'b1);
      look();
      wait_ack(0);
      step();
      miss_req_i[0] = 1'b0;
      wait_ack(1);
      step();
      miss_req_i[1] = 1'b0;
      rtrn(0, 3'b001);
      rtrn(1, 3'b010);

      // collision with an in-flight line
      req(0, 56'h8000_0040, 4'b0000, 1'b0, 3'b111, 4'b0001, 1'b1);
      look();
      wait_ack(0);
      step();
      miss_req_i[0] = 1'b0;
      req(1, 56'h8000_0058, 4'b0000, 1'b0, 3'b111, 4'b0001, 1'b0);
      look();
      chk("t3_replay", 64'(miss_replay_o), 64'(3'b010));
      chk("t3_no_mem_req", 64'(mem_req_o), 0);
      step();
      miss_req_i[1] = 1'b0;
      look();
      chk("t3_no_mem_req_after", 64'(mem_req_o), 0);
      rtrn(0, 3'b001);
      req(1, 56'h8000_0058, 4'b0000, 1'b0, 3'b111, 4'b0001, 1'b1);
      look();
      chk("t3_no_replay_after_rtrn", 64'(miss_replay_o), 0);
      wait_ack(1);
      step();
      miss_req_i[1] = 1'b0;

      // all ways valid: way from LFSR seed, then from the advanced LFSR
      rst_ni = 1'b0;
      step();
      rst_ni = 1'b1;
      step();
      req(0, 56'h8000_6000, 4'b1111, 1'b0, 3'b111, 4'b0010, 1'b1);
      look();
      wait_ack(0);
      step();
      miss_req_i[0] = 1'b0;
      req(1, 56'h8000_7000, 4'b1111, 1'b0, 3'b111, 4'b0100, 1'b1);
      look();
      wait_ack(1);
      step();
      miss_req_i[1] = 1'b0;

      // noncacheable request
      req(2, 56'h8000_8008, 4'b0000, 1'b1, 3'b010, 4'b0000, 1'b1);
      look();
      wait_ack(2);
      chk("t5_nc", 64'(mem_nc_o), 1);
      chk("t5_size", 64'(mem_size_o), 64'(3'b010));
      step();
      miss_req_i[2] = 1'b0;
      miss_nc_i[2]  = 1'b0;

      // grant held low, then reset mid-wait
      rtrn(0, 3'b001);
      mem_gnt_i = 1'b0;
      req(0, 56'h8000_9000, 4'b0000, 1'b0, 3'b111, 4'b0001, 1'b0);
      look();
      for (int i = 0; i < 5; i++) begin
         step();
         look();
         chk($sformatf("t6_req_c%0d", i), 64'(mem_req_o), 1);
         chk($sformatf("t6_paddr_c%0d", i), 64'(mem_paddr_o), 64'h8000_9000);
         chk($sformatf("t6_id_c%0d", i), 64'(mem_id_o), 0);
      end
      step();
      rst_ni     = 1'b0;
      miss_req_i = '0;
      look();
      chk("t6_rst_mem_req", 64'(mem_req_o), 0);
      chk("t6_rst_pulses", 64'({miss_ack_o, miss_replay_o, miss_rtrn_vld_o}), 0);
      chk("t6_rst_fields", 64'({mem_paddr_o, mem_id_o, mem_way_o, mem_nc_o, mem_size_o}), 0);
      step();
      rst_ni    = 1'b1;
      mem_gnt_i = 1'b1;
      step();
      req(2, 56'h8000_7010, 4'b0000, 1'b0, 3'b111, 4'b0001, 1'b1);
      look();
      chk("t6_tbl_empty_no_replay", 64'(miss_replay_o), 0);
      wait_ack(2);
      step();
      miss_req_i[2] = 1'b0;
      rtrn(2, 3'b100);

      step();
      chk("sb_drained", 64'(exp_q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
